// File: rtl/foosball_pkg.sv
`default_nettype none
// ============================================================================
// Module   : foosball_pkg
// Brief    : Shared types and defaults for the foosball rod movers.
// Revision : 1.0 - initial release
// ============================================================================
package foosball_pkg;

    localparam int DEFAULT_COORD_W = 11;

    // Encoding doubles as the kick sprite index.
    typedef enum logic [1:0] {
        KS_IDLE = 2'd0,
        KS_FWD  = 2'd1,
        KS_HOLD = 2'd2,
        KS_BACK = 2'd3
    } kick_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } move_dir_t;

endpackage
`default_nettype wire

// File: rtl/kick_fsm.sv
`default_nettype none
// ============================================================================
// Module   : kick_fsm
// Brief    : Kick key edge detect and timed IDLE->FWD->HOLD->BACK animation.
// Revision : 1.0 - initial release
// ============================================================================
module kick_fsm
    import foosball_pkg::*;
#(
    parameter int KICK_TICKS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_done,
    input  logic        kick,
    output kick_state_t state,
    output logic        kick_active,
    output logic        kick_start
);

    localparam int            PW         = (KICK_TICKS > 1) ? $clog2(KICK_TICKS) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(KICK_TICKS - 1);

    kick_state_t   state_n;
    logic          kick_q;
    logic          kick_pending;
    logic          pending_n;
    logic [PW-1:0] phase_cnt;
    logic [PW-1:0] phase_n;
    logic          kick_rise;
    logic          phase_done;

    assign kick_rise   = kick & ~kick_q;
    assign phase_done  = (phase_cnt == PHASE_LAST);
    assign kick_active = (state == KS_FWD) || (state == KS_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= KS_IDLE;
            kick_q       <= 1'b0;
            kick_pending <= 1'b0;
            phase_cnt    <= '0;
        end else begin
            state        <= state_n;
            kick_q       <= kick;
            kick_pending <= pending_n;
            phase_cnt    <= phase_n;
        end
    end

    always_comb begin
        state_n    = state;
        pending_n  = kick_pending;
        phase_n    = phase_cnt;
        kick_start = 1'b0;
        case (state)
            KS_IDLE: begin
                // Starting the kick wins over a coincident new edge.
                if (timer_done && kick_pending) begin
                    kick_start = 1'b1;
                    pending_n  = 1'b0;
                    phase_n    = '0;
                    state_n    = KS_FWD;
                end else if (kick_rise) begin
                    pending_n = 1'b1;
                end
            end
            default: begin
                if (timer_done) begin
                    if (phase_done) begin
                        phase_n = '0;
                        case (state)
                            KS_FWD:  state_n = KS_HOLD;
                            KS_HOLD: state_n = KS_BACK;
                            default: state_n = KS_IDLE;
                        endcase
                    end else begin
                        phase_n = phase_cnt + PW'(1);
                    end
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rod_move.sv
`default_nettype none
// ============================================================================
// Module   : rod_move
// Brief    : Foosball rod mover: bordered vertical travel, speed ramp, kick.
// Revision : 1.0 - initial release
// ============================================================================
module rod_move
    import foosball_pkg::*;
#(
    parameter int NUM_PLAYERS   = 3,
    parameter int COORD_W       = DEFAULT_COORD_W,
    parameter int START_X       = 20,
    parameter int START_Y       = 220,
    parameter int SPACING       = 80,
    parameter int TOP_BORDER    = 130,
    parameter int BOTTOM_BORDER = 329,
    parameter int STEP_MIN      = 1,
    parameter int STEP_MAX      = 4,
    parameter int ACCEL_TICKS   = 8,
    parameter int KICK_TICKS    = 6,
    parameter int KICK_DX       = 12
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           timer_done,
    input  logic                           up_direction,
    input  logic                           down_direction,
    input  logic                           kick,
    output logic [COORD_W-1:0]             ObjectStartX,
    output logic [NUM_PLAYERS*COORD_W-1:0] ObjectStartY,
    output logic                           kick_active,
    output logic [1:0]                     kick_frame,
    output logic                           at_top,
    output logic                           at_bottom
);

    localparam int                 CW1       = COORD_W + 1;
    localparam int                 SW        = $clog2(STEP_MAX + 1);
    localparam int                 HW        = $clog2(ACCEL_TICKS + 1) + 1;
    localparam logic [CW1-1:0]     TOP_EXT   = CW1'(TOP_BORDER);
    localparam logic [CW1-1:0]     BOT_EXT   = CW1'(BOTTOM_BORDER);
    localparam logic [SW-1:0]      STEP_LO   = SW'(STEP_MIN);
    localparam logic [SW-1:0]      STEP_HI   = SW'(STEP_MAX);
    localparam logic [HW-1:0]      ACCEL_LIM = HW'(ACCEL_TICKS);
    localparam logic [COORD_W-1:0] X_REST    = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] X_HALF    = COORD_W'(START_X + KICK_DX / 2);
    localparam logic [COORD_W-1:0] X_FULL    = COORD_W'(START_X + KICK_DX);

    if (START_Y < TOP_BORDER || START_Y > BOTTOM_BORDER) begin : g_bad_start
        $error("rod_move: START_Y outside the borders");
    end
    if (STEP_MIN > STEP_MAX) begin : g_bad_step
        $error("rod_move: STEP_MIN exceeds STEP_MAX");
    end
    if (BOTTOM_BORDER + (NUM_PLAYERS - 1) * SPACING >= (2 ** COORD_W)) begin : g_bad_width
        $error("rod_move: lowest player does not fit in COORD_W");
    end
    if (KICK_TICKS < 1 || ACCEL_TICKS < 1) begin : g_bad_ticks
        $error("rod_move: KICK_TICKS and ACCEL_TICKS must be at least 1");
    end

    kick_state_t        fsm_state;
    logic               kick_start;
    logic [COORD_W-1:0] rod_y;
    logic [COORD_W-1:0] rod_y_n;
    logic [SW-1:0]      step;
    logic [SW-1:0]      step_n;
    logic [SW-1:0]      step_use;
    logic [HW-1:0]      hold_cnt;
    logic [HW-1:0]      hold_n;
    logic [HW-1:0]      hold_inc;
    move_dir_t          last_dir;
    move_dir_t          last_n;
    move_dir_t          req_dir;
    logic [CW1-1:0]     y_ext;
    logic [CW1-1:0]     step_ext;
    logic [CW1-1:0]     up_floor;
    logic [CW1-1:0]     y_up;
    logic [CW1-1:0]     y_down_raw;
    logic [CW1-1:0]     y_down;

    kick_fsm #(
        .KICK_TICKS (KICK_TICKS)
    ) u_kick_fsm (
        .clk         (CLK),
        .rst         (RESET),
        .timer_done  (timer_done),
        .kick        (kick),
        .state       (fsm_state),
        .kick_active (kick_active),
        .kick_start  (kick_start)
    );

    always_comb begin
        req_dir = DIR_NONE;
        if (up_direction && !down_direction) begin
            req_dir = DIR_UP;
        end else if (down_direction && !up_direction) begin
            req_dir = DIR_DOWN;
        end
    end

    // A direction change restarts the ramp at the slowest step this tick.
    assign step_use   = (req_dir != last_dir) ? STEP_LO : step;
    assign y_ext      = {1'b0, rod_y};
    assign step_ext   = CW1'(step_use);
    assign up_floor   = TOP_EXT + step_ext;
    assign y_up       = (y_ext < up_floor) ? TOP_EXT : (y_ext - step_ext);
    assign y_down_raw = y_ext + step_ext;
    assign y_down     = (y_down_raw > BOT_EXT) ? BOT_EXT : y_down_raw;
    assign hold_inc   = hold_cnt + HW'(1);

    always_comb begin
        rod_y_n = rod_y;
        step_n  = step;
        hold_n  = hold_cnt;
        last_n  = last_dir;
        if (kick_start) begin
            step_n = STEP_LO;
            hold_n = '0;
        end else if (timer_done && (fsm_state == KS_IDLE)) begin
            if (req_dir == DIR_NONE) begin
                step_n = STEP_LO;
                hold_n = '0;
                last_n = DIR_NONE;
            end else begin
                rod_y_n = (req_dir == DIR_UP) ? y_up[COORD_W-1:0] : y_down[COORD_W-1:0];
                if (req_dir != last_dir) begin
                    step_n = STEP_LO;
                    hold_n = HW'(1);
                    last_n = req_dir;
                end else if (hold_inc >= ACCEL_LIM) begin
                    hold_n = '0;
                    step_n = (step < STEP_HI) ? (step + SW'(1)) : STEP_HI;
                end else begin
                    hold_n = hold_inc;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rod_y    <= COORD_W'(START_Y);
            step     <= STEP_LO;
            hold_cnt <= '0;
            last_dir <= DIR_NONE;
        end else begin
            rod_y    <= rod_y_n;
            step     <= step_n;
            hold_cnt <= hold_n;
            last_dir <= last_n;
        end
    end

    always_comb begin
        ObjectStartX = X_REST;
        case (fsm_state)
            KS_FWD, KS_BACK: ObjectStartX = X_HALF;
            KS_HOLD:         ObjectStartX = X_FULL;
            default:         ObjectStartX = X_REST;
        endcase
    end

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_players
        assign ObjectStartY[i*COORD_W +: COORD_W] = rod_y + COORD_W'(i * SPACING);
    end

    assign kick_frame = fsm_state;
    assign at_top     = (rod_y == COORD_W'(TOP_BORDER));
    assign at_bottom  = (rod_y == COORD_W'(BOTTOM_BORDER));

endmodule
`default_nettype wire

// File: tb/tb_rod_move.sv
`default_nettype none
// ============================================================================
// Module   : tb_rod_move
// Brief    : Self-checking bench for rod_move (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rod_move;

    localparam int CW = 11;
    localparam int NP = 3;

    typedef struct {
        bit rst;
        bit up;
        bit down;
        bit kick;
        int y;
        int x;
        int frame;
        bit active;
    } vec_t;

    logic clk        = 1'b0;
    logic rst        = 1'b0;
    logic timer_done = 1'b0;
    logic up_in      = 1'b0;
    logic down_in    = 1'b0;
    logic kick_in    = 1'b0;

    logic [CW-1:0]    x_a, x_b, x_c;
    logic [NP*CW-1:0] y_a, y_b, y_c;
    logic             act_a, act_b, act_c;
    logic [1:0]       frame_a, frame_b, frame_c;
    logic             top_a, top_b, top_c;
    logic             bot_a, bot_b, bot_c;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rod_move u_dut (
        .CLK(clk), .RESET(rst), .timer_done(timer_done), .up_direction(up_in),
        .down_direction(down_in), .kick(kick_in), .ObjectStartX(x_a), .ObjectStartY(y_a),
        .kick_active(act_a), .kick_frame(frame_a), .at_top(top_a), .at_bottom(bot_a)
    );

    rod_move #(.START_Y(328), .STEP_MIN(4)) u_bot (
        .CLK(clk), .RESET(rst), .timer_done(timer_done), .up_direction(up_in),
        .down_direction(down_in), .kick(kick_in), .ObjectStartX(x_b), .ObjectStartY(y_b),
        .kick_active(act_b), .kick_frame(frame_b), .at_top(top_b), .at_bottom(bot_b)
    );

    rod_move #(.START_Y(131), .STEP_MIN(4)) u_top (
        .CLK(clk), .RESET(rst), .timer_done(timer_done), .up_direction(up_in),
        .down_direction(down_in), .kick(kick_in), .ObjectStartX(x_c), .ObjectStartY(y_c),
        .kick_active(act_c), .kick_frame(frame_c), .at_top(top_c), .at_bottom(bot_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        timer_done = 1'b0;
        up_in      = 1'b0;
        down_in    = 1'b0;
        kick_in    = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_kick();
        kick_in = 1'b1;
        @(posedge clk);
        #1 kick_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One timer tick followed by an idle cycle; outputs are stable on return.
    task automatic tick(input bit up, input bit down);
        up_in      = up;
        down_in    = down;
        timer_done = 1'b1;
        @(posedge clk);
        #1 timer_done = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic void addv(input bit r, input bit u, input bit d, input bit k,
                                 input int y, input int x, input int f, input bit a);
        vec_t v;
        v.rst = r; v.up = u; v.down = d; v.kick = k;
        v.y = y; v.x = x; v.frame = f; v.active = a;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t e;
        int   f;

        // Ramp: 8 ticks at step 1, then 8 at step 2; release resets the step.
        for (int i = 0; i < 16; i++) begin
            addv(i == 0, 1'b1, 1'b0, 1'b0, (i < 8) ? (219 - i) : (212 - 2 * (i - 7)), 20, 0, 1'b0);
        end
        addv(1'b0, 1'b0, 1'b0, 1'b0, 196, 20, 0, 1'b0);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 195, 20, 0, 1'b0);
        // Both keys held: no movement and no ramp.
        for (int i = 0; i < 5; i++) begin
            addv(i == 0, 1'b1, 1'b1, 1'b0, 220, 20, 0, 1'b0);
        end
        addv(1'b0, 1'b1, 1'b0, 1'b0, 219, 20, 0, 1'b0);
        // Kick with up held; second kick edge lands during HOLD.
        for (int t = 1; t <= 20; t++) begin
            f = (t < 7) ? 1 : (t < 13) ? 2 : (t < 19) ? 3 : 0;
            addv(t == 1, 1'b1, 1'b0, (t == 1) || (t == 9), (t < 20) ? 220 : 219,
                 (f == 0) ? 20 : (f == 2) ? 32 : 26, f, (f == 1) || (f == 2));
        end

        // Reset state of all three instances.
        do_reset(2);
        check("rst_x",      32'(x_a), 20);
        check("rst_y0",     32'(y_a[CW-1:0]), 220);
        check("rst_y1",     32'(y_a[2*CW-1:CW]), 300);
        check("rst_y2",     32'(y_a[3*CW-1:2*CW]), 380);
        check("rst_frame",  32'(frame_a), 0);
        check("rst_active", 32'(act_a), 0);
        check("rst_top",    32'(top_a), 0);
        check("rst_bot",    32'(bot_a), 0);
        check("rst_b_x",    32'(x_b), 20);
        check("rst_b_y2",   32'(y_b[3*CW-1:2*CW]), 488);
        check("rst_b_fa",   32'({frame_b, act_b, top_b, bot_b}), 0);
        check("rst_c_x",    32'(x_c), 20);
        check("rst_c_y1",   32'(y_c[2*CW-1:CW]), 211);
        check("rst_c_fa",   32'({frame_c, act_c, top_c, bot_c}), 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset(2);
            if (vecs[i].kick) pulse_kick();
            exp_q.push_back(vecs[i]);
            tick(vecs[i].up, vecs[i].down);
            e = exp_q.pop_front();
            check($sformatf("v%0d_y0", i),     32'(y_a[CW-1:0]), 32'(e.y));
            check($sformatf("v%0d_y1", i),     32'(y_a[2*CW-1:CW]), 32'(e.y + 80));
            check($sformatf("v%0d_x", i),      32'(x_a), 32'(e.x));
            check($sformatf("v%0d_frame", i),  32'(frame_a), 32'(e.frame));
            check($sformatf("v%0d_active", i), 32'(act_a), 32'(e.active));
        end

        // Bottom border saturates instead of overshooting.
        do_reset(2);
        tick(1'b0, 1'b1);
        check("bot_y",    32'(y_b[CW-1:0]), 329);
        check("bot_flag", 32'(bot_b), 1);
        tick(1'b0, 1'b1);
        check("bot_y_hold", 32'(y_b[CW-1:0]), 329);
        check("bot_flag2",  32'(bot_b), 1);

        // Top border saturates instead of underflowing.
        do_reset(2);
        tick(1'b1, 1'b0);
        check("top_y",    32'(y_c[CW-1:0]), 130);
        check("top_flag", 32'(top_c), 1);
        tick(1'b1, 1'b0);
        check("top_y_hold", 32'(y_c[CW-1:0]), 130);

        // Reset in the middle of a kick and of a ramp.
        do_reset(2);
        repeat (16) tick(1'b1, 1'b0);
        check("mid_y", 32'(y_a[CW-1:0]), 196);
        pulse_kick();
        repeat (7) tick(1'b1, 1'b0);
        check("mid_frame", 32'(frame_a), 2);
        check("mid_x",     32'(x_a), 32);
        do_reset(1);
        check("mr_frame", 32'(frame_a), 0);
        check("mr_x",     32'(x_a), 20);
        check("mr_y",     32'(y_a[CW-1:0]), 220);
        tick(1'b1, 1'b0);
        check("mr_step1", 32'(y_a[CW-1:0]), 219);
        tick(1'b1, 1'b0);
        check("mr_step1b", 32'(y_a[CW-1:0]), 218);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rod_move.md
Name: rod_move

Overview:
- Parametrised successor of the single-player mover. Drives a full foosball rod of NUM_PLAYERS players that share one vertical rod offset.
- Adds saturating borders, hold-to-accelerate speed ramp, and a timed kick animation FSM.
- Sits between keyboard/timer logic and the VGA object drawers. Each player drawer takes its X/Y slice.

Parameters:
- NUM_PLAYERS, 3, players on the rod.
- COORD_W, 11, coordinate width.
- START_X, 20, rod X at rest.
- START_Y, 220, reset Y of player 0 (rod offset).
- SPACING, 80, vertical pixel distance between adjacent players.
- TOP_BORDER, 130, minimum rod offset.
- BOTTOM_BORDER, 329, maximum rod offset.
- STEP_MIN, 1, initial pixels per tick.
- STEP_MAX, 4, maximum pixels per tick.
- ACCEL_TICKS, 8, consecutive moving ticks before step increments.
- KICK_TICKS, 6, timer ticks spent in each kick phase.
- KICK_DX, 12, X displacement at full kick extension.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- timer_done  in  1  one-cycle movement tick
- up_direction  in  1  up key level
- down_direction  in  1  down key level
- kick  in  1  kick key level
- ObjectStartX  out  COORD_W  rod X incl. kick offset
- ObjectStartY  out  NUM_PLAYERS*COORD_W  packed; slice i = player i Y
- kick_active  out  1  high in FWD and HOLD (ball-hit window)
- kick_frame  out  2  sprite select: 0 IDLE, 1 FWD, 2 HOLD, 3 BACK
- at_top  out  1  rod_y == TOP_BORDER
- at_bottom  out  1  rod_y == BOTTOM_BORDER

Behaviour:
- Interface: one clock CLK. Reset is synchronous and active-high on RESET.
- Reset values:
  - rod_y=START_Y, step=STEP_MIN, hold_cnt=0, last_dir=NONE.
  - FSM=IDLE, kick_pending=0, phase_cnt=0.
  - Outputs: ObjectStartX=START_X, slice i = START_Y+i*SPACING, kick_active=0, kick_frame=0.
  - at_top/at_bottom reflect START_Y.
  - RESET mid-kick or mid-ramp returns everything to these values on the next edge.
- Outputs are combinational from registers only. A timer_done edge updates state, visible the next cycle (1-cycle latency).
- Move request, evaluated only when timer_done=1 and FSM==IDLE:
  - up only -> UP; down only -> DOWN.
  - Both or neither -> NONE: no move, step=STEP_MIN, hold_cnt=0.
- UP: rod_y = max(rod_y-step, TOP_BORDER). DOWN: rod_y = min(rod_y+step, BOTTOM_BORDER).
  - Compute in COORD_W+1 bits. No underflow or overshoot.
- Ramp:
  - If dir==last_dir, hold_cnt++. When hold_cnt reaches ACCEL_TICKS: hold_cnt=0, step=min(step+1, STEP_MAX).
  - A direction change applies STEP_MIN this tick, sets hold_cnt=1 and latches last_dir.
  - Moving into a border already reached still counts as a moving tick.
- Kick edge detect: kick registered every clock. A rising edge while FSM==IDLE sets kick_pending. Edges outside IDLE are ignored.
- FSM, IDLE->FWD->HOLD->BACK->IDLE:
  - IDLE->FWD on timer_done with kick_pending. This clears kick_pending, phase_cnt=0, step=STEP_MIN, hold_cnt=0.
  - Other states advance after KICK_TICKS timer_done ticks (phase_cnt reaches KICK_TICKS-1, then resets).
  - Kick takes priority over movement on the same tick. Vertical movement is frozen outside IDLE.
- ObjectStartX:
  - START_X in IDLE.
  - START_X+KICK_DX/2 in FWD and BACK.
  - START_X+KICK_DX in HOLD.
- Elaboration asserts:
  - TOP_BORDER<=START_Y<=BOTTOM_BORDER.
  - STEP_MIN<=STEP_MAX.
  - BOTTOM_BORDER+(NUM_PLAYERS-1)*SPACING < 2**COORD_W.
  - KICK_TICKS>=1 and ACCEL_TICKS>=1.

Decomposition:
- foosball_pkg holds:
  - kick_state_t enum {IDLE, FWD, HOLD, BACK}, 2-bit, encoding equals kick_frame.
  - move_dir_t {NONE, UP, DOWN}.
  - Default COORD_W.
- Sub-module kick_fsm owns edge detect, kick_pending, phase_cnt and state. It outputs state and kick_active.
- rod_move owns position, ramp, X/Y mapping.

Test Plan:
- Defaults, RESET 2 cycles then release -> X=20, Y slices 220/300/380, kick_frame=0, at_top=at_bottom=0.
- up_direction held for 16 timer ticks -> rod_y 219..212 over first 8 ticks, step=2 afterwards, rod_y=196 after tick 16. Release -> next tick no move, step back to 1.
- START_Y=328, STEP_MIN=4, one down tick -> rod_y=329 (not 332), at_bottom=1. Further down ticks keep 329.
- Up and down both held 5 ticks -> rod_y unchanged at 220, step stays 1.
- Kick pulse then 18 ticks:
  - Next tick enters FWD (X=26, kick_active=1).
  - After 6 ticks HOLD (X=32), after 6 more BACK (X=26, kick_active=0), after 6 more IDLE (X=20).
  - up_direction held throughout leaves rod_y unchanged until IDLE.
  - Second kick edge during HOLD is ignored.
- RESET asserted during HOLD with rod_y=180 -> next cycle FSM IDLE, X=20, rod_y=220, step=1.
